sw_n: RTL

Parametrised N-port input-buffered packet switch; next generation of the fixed 4-way switch. Each input port has a DEPTH-deep flit FIFO with valid/ready backpressure. Each output port has an arbiter and a registered output stage with valid/ready handshake. Flits carry a destination field on ingress; the switch strips it and replaces it with the source port index on egress.

---
 rtl/sw_n_pkg.sv | 13 +
 rtl/sw_n_arb.sv | 41 ++++
 rtl/sw_n.sv | 111 +++++++++++
 3 files changed

// File: rtl/sw_n_pkg.sv
// sw_n_pkg: flit layout helpers and port-index type shared by the sw_n switch.
// A flit is {dest|src, payload}: index at [PORTW+DW-1:DW], payload at [DW-1:0].
package sw_n_pkg;
    localparam int MAX_NPORT = 16;
    localparam int MAX_PORTW = $clog2(MAX_NPORT);
    typedef logic [MAX_PORTW-1:0] port_idx_t;
    function automatic int flit_w(input int portw, input int dw);
        return portw + dw;
    endfunction
    function automatic int idx_lo(input int dw);
        return dw;
    endfunction
endpackage

// File: rtl/sw_n_arb.sv
// sw_n_arb: per-output arbiter, one-hot grant only when the output stage can load.
// SWN_RR_EN selects round-robin (pointer moves past the winner); otherwise lowest index wins.
module sw_n_arb
    import sw_n_pkg::*;
#(
    parameter int NPORT = 4
) (
`ifdef SWN_RR_EN
    input  logic             clk,
    input  logic             rst,
`endif
    input  logic             en,
    input  logic [NPORT-1:0] req,
    output logic [NPORT-1:0] gnt
);
`ifdef SWN_RR_EN
    localparam int PW = $clog2(NPORT);
    logic [PW-1:0] ptr_q, ptr_d;
    always_comb begin
        gnt = '0;
        ptr_d = ptr_q;
        // Scan from lowest priority up so the highest-priority requester is written last.
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % NPORT]) begin
                gnt = NPORT'(1) << ((int'(ptr_q) + k) % NPORT);
                ptr_d = PW'((int'(ptr_q) + k + 1) % NPORT);
            end
        end
        if (!en) begin
            gnt = '0;
            ptr_d = ptr_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
`else
    assign gnt = en ? (req & (~req + NPORT'(1))) : '0;
`endif
endmodule

// File: rtl/sw_n.sv
// sw_n: NPORT-way input-buffered packet switch; dest field swapped for source index on egress.
// Optional SWN_RR_EN macro enables round-robin arbitration per output.
module sw_n
    import sw_n_pkg::*;
#(
    parameter int NPORT = 4,
    parameter int DW = 8,
    parameter int DEPTH = 4,
    localparam int PORTW = $clog2(NPORT),
    localparam int FW = flit_w(PORTW, DW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    in_valid,
    output logic [NPORT-1:0]    in_ready,
    input  logic [NPORT*FW-1:0] in_flit,
    output logic [NPORT-1:0]    out_valid,
    input  logic [NPORT-1:0]    out_ready,
    output logic [NPORT*FW-1:0] out_flit,
    output logic [NPORT-1:0]    drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LO = idx_lo(DW);

    logic [FW-1:0]    head [NPORT];
    logic [FW-1:0]    nf [NPORT];
    logic [FW-1:0]    of_q [NPORT];
    logic [NPORT-1:0] req [NPORT];
    logic [NPORT-1:0] gnt [NPORT];
    logic [NPORT-1:0] ne, bad, pop, ld, ov_q, drop_q;

    for (genvar i = 0; i < NPORT; i++) begin : g_in
        logic [FW-1:0] mem_q [DEPTH];
        logic [AW-1:0] wp_q, rp_q;
        logic [CW-1:0] cnt_q;
        logic          push;
        assign in_ready[i] = cnt_q != CW'(DEPTH);
        assign push = in_valid[i] && in_ready[i];
        assign ne[i] = cnt_q != '0;
        assign head[i] = mem_q[rp_q];
        // Out-of-range destinations are flushed instead of blocking the FIFO.
        assign bad[i] = ne[i] && (32'(head[i][FW-1:LO]) >= 32'(NPORT));
        always_ff @(posedge clk) begin
            if (push) mem_q[wp_q] <= in_flit[i*FW +: FW];
        end
        always_ff @(posedge clk) begin
            if (!rst) begin
                wp_q <= '0;
                rp_q <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wp_q <= (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
                if (pop[i]) rp_q <= (rp_q == AW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
                cnt_q <= cnt_q + CW'(push) - CW'(pop[i]);
            end
        end
    end

    assign ld = ~ov_q | out_ready;

    always_comb begin
        for (int o = 0; o < NPORT; o++)
            for (int i = 0; i < NPORT; i++)
                req[o][i] = ne[i] && (head[i][FW-1:LO] == PORTW'(o));
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        sw_n_arb #(.NPORT(NPORT)) u_arb (
`ifdef SWN_RR_EN
            .clk (clk),
            .rst (rst),
`endif
            .en  (ld[o]),
            .req (req[o]),
            .gnt (gnt[o])
        );
        assign out_flit[o*FW +: FW] = of_q[o];
    end

    always_comb begin
        pop = bad;
        for (int o = 0; o < NPORT; o++) begin
            pop = pop | gnt[o];
            nf[o] = '0;
            for (int i = 0; i < NPORT; i++)
                if (gnt[o][i]) nf[o] = {PORTW'(i), head[i][DW-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ov_q <= '0;
            drop_q <= '0;
            for (int o = 0; o < NPORT; o++) of_q[o] <= '0;
        end else begin
            drop_q <= bad;
            for (int o = 0; o < NPORT; o++) begin
                if (|gnt[o]) begin
                    ov_q[o] <= 1'b1;
                    of_q[o] <= nf[o];
                end else if (out_ready[o]) begin
                    ov_q[o] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = ov_q;
    assign drop = drop_q;
endmodule
